// File: rtl/matmul_feeder.sv
// matmul_feeder
//   Collects fp16 words from a single input stream and presents them to a
//   downstream 4x4 matrix-vector unit. Matrix words fill a 16-entry shadow
//   buffer. When the 16th word arrives, the whole shadow is committed to a.
//   Vertex words fill a 4-entry buffer. A complete vertex is loaded into b
//   together with a one-cycle issue pulse, but only once a matrix has been
//   committed. out_valid replays issue after MM_LATENCY cycles.
//   A new matrix word is held off (in_ready low) while any product is in
//   flight, so a is never modified under an active multiply.
//
// Parameters
//   MM_LATENCY  cycles from issue to the matching downstream result
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_data     fp16 word (matrix coefficient or vertex component)
//   in_mat      1 = matrix word, 0 = vertex word
//   in_valid    word present
//   in_ready    word accepted when in_valid && in_ready
//   a           committed 4x4 matrix, element k at [16k+15:16k]
//   b           current vertex, component j at [16j+15:16j]
//   issue       pulse in the cycle b takes a new vertex
//   out_valid   issue delayed by MM_LATENCY cycles
//   mat_loaded  a holds a complete matrix
//   err         sticky protocol error (cleared only by reset)
//
// Configuration macro
//   MATMUL_FEEDER_TRANSPOSE_EN  defined: matrix words arrive column-major
//                               undefined: matrix words arrive row-major

module matmul_feeder #(
  parameter int MM_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  in_data,
  input  logic         in_mat,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [255:0] a,
  output logic [63:0]  b,
  output logic         issue,
  output logic         out_valid,
  output logic         mat_loaded,
  output logic         err
);

  logic [15:0]           shadow_reg [16];
  logic [15:0]           vtx_reg [4];
  logic [3:0]            mat_idx_reg;
  logic [1:0]            vtx_idx_reg;
  logic [MM_LATENCY-1:0] inflight_reg;

  logic       busy;
  logic       accept;
  logic [3:0] widx;
  logic [255:0] a_next;

  assign busy     = (|inflight_reg) | issue;
  // Held high through reset so upstream never sees a stall from stale state.
  assign in_ready = rst | ~(in_mat & busy);
  assign accept   = in_valid & in_ready;
  assign out_valid = inflight_reg[MM_LATENCY-1];

`ifdef MATMUL_FEEDER_TRANSPOSE_EN
  // Word n lands at element 4*(n%4) + n/4: swap the two index halves.
  assign widx = {mat_idx_reg[1:0], mat_idx_reg[3:2]};
`else
  assign widx = mat_idx_reg;
`endif

  // Commit image: the shadow with the word being written this cycle merged
  // in, so the final word reaches a on the same edge as the others.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_commit
      assign a_next[16*gi +: 16] = (widx == 4'(gi)) ? in_data : shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      a            <= '0;
      b            <= '0;
      issue        <= 1'b0;
      mat_loaded   <= 1'b0;
      err          <= 1'b0;
      mat_idx_reg  <= '0;
      vtx_idx_reg  <= '0;
      inflight_reg <= '0;
      for (int k = 0; k < 16; k++) shadow_reg[k] <= '0;
      for (int k = 0; k < 4; k++)  vtx_reg[k]    <= '0;
    end else begin
      issue <= 1'b0;
      for (int i = MM_LATENCY - 1; i > 0; i--) inflight_reg[i] <= inflight_reg[i-1];
      inflight_reg[0] <= issue;

      if (accept && in_mat) begin
        shadow_reg[widx] <= in_data;
        mat_idx_reg      <= mat_idx_reg + 4'd1;
        if (mat_idx_reg == 4'd15) begin
          a          <= a_next;
          mat_loaded <= 1'b1;
        end
        // A matrix word in the middle of a vertex abandons that vertex.
        if (vtx_idx_reg != 2'd0) begin
          vtx_idx_reg <= '0;
          err         <= 1'b1;
        end
      end else if (accept) begin
        vtx_reg[vtx_idx_reg] <= in_data;
        vtx_idx_reg          <= vtx_idx_reg + 2'd1;
        if (vtx_idx_reg == 2'd3) begin
          if (mat_loaded) begin
            b     <= {in_data, vtx_reg[2], vtx_reg[1], vtx_reg[0]};
            issue <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_feeder.sv
// Directed bench for matmul_feeder: reset state, matrix commit, vertex issue
// and latency, back-to-back issue, matrix back-pressure, protocol errors and
// reset while results are in flight.

module tb_matmul_feeder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  in_data = '0;
  logic         in_mat = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] a;
  logic [63:0]  b;
  logic         issue;
  logic         out_valid;
  logic         mat_loaded;
  logic         err;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int iss_q[$];
  int ov_q[$];

  matmul_feeder #(.MM_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_mat(in_mat),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .issue(issue),
    .out_valid(out_valid), .mat_loaded(mat_loaded), .err(err)
  );

  always #5 clk = ~clk;

  // Timestamp issue and out_valid pulses away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (issue) iss_q.push_back(cyc);
    if (out_valid) ov_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word, wait (bounded) for in_ready, complete the handshake.
  // Returns with outputs as they stand in the cycle after the handshake.
  task automatic send(input logic [15:0] d, input logic m, output int waits);
    in_data = d; in_mat = m; in_valid = 1'b1; waits = 0;
    #1;
    while (!in_ready && waits < 20) begin
      step();
      waits++;
    end
    if (!in_ready) check("send_timeout", {255'd0, in_ready}, 256'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Expected committed matrix for words base+0 .. base+15.
  function automatic logic [255:0] exp_mat(input logic [15:0] base);
    logic [255:0] r;
    int n;
    r = '0;
    for (int k = 0; k < 16; k++) begin
`ifdef MATMUL_FEEDER_TRANSPOSE_EN
      n = 4 * (k % 4) + k / 4;
`else
      n = k;
`endif
      r[16*k +: 16] = base + 16'(n);
    end
    return r;
  endfunction

  initial begin
    int w;
    int g0, g1, g2;
    logic [255:0] m3c;
    logic [255:0] m50;
    m3c = exp_mat(16'h3C00);
    m50 = exp_mat(16'h5000);

    // Reset state; in_ready must stay high even with a matrix word offered.
    in_mat = 1'b1; in_valid = 1'b1;
    step(); step();
    check("rst_in_ready", {255'd0, in_ready}, 256'd1);
    in_mat = 1'b0; in_valid = 1'b0;
    rst = 1'b0;
    step();
    check("rst_a", a, 256'd0);
    check("rst_b", {192'd0, b}, 256'd0);
    check("rst_flags", {251'd0, issue, out_valid, mat_loaded, err, in_ready}, 256'd1);

    // Vertex before any matrix: dropped, error.
    for (int j = 0; j < 4; j++) send(16'h4000 + 16'(j << 8), 1'b0, w);
    check("nomat_issue", {255'd0, issue}, 256'd0);
    check("nomat_b", {192'd0, b}, 256'd0);
    check("nomat_err", {255'd0, err}, 256'd1);
    step();
    check("nomat_no_issue_seen", 256'(iss_q.size()), 256'd0);

    rst = 1'b1; step(); rst = 1'b0; step();
    check("rst2_err", {255'd0, err}, 256'd0);

    // Matrix load 0x3C00..0x3C0F; a changes only on the 16th word.
    for (int n = 0; n < 16; n++) begin
      send(16'h3C00 + 16'(n), 1'b1, w);
      if (n == 14) begin
        check("mat15_loaded", {255'd0, mat_loaded}, 256'd0);
        check("mat15_a", a, 256'd0);
      end
    end
    check("mat_loaded", {255'd0, mat_loaded}, 256'd1);
    check("mat_a", a, m3c);
`ifdef MATMUL_FEEDER_TRANSPOSE_EN
    check("tr_elem1", {240'd0, a[31:16]}, 256'h3C04);
    check("tr_elem4", {240'd0, a[79:64]}, 256'h3C01);
`endif

    // Vertex issue, then out_valid exactly 4 cycles later.
    for (int j = 0; j < 4; j++) send(16'h4000 + 16'(j << 8), 1'b0, w);
    check("vtx_issue", {255'd0, issue}, 256'd1);
    check("vtx_b", {192'd0, b}, {192'd0, 64'h4300_4200_4100_4000});
    for (int i = 1; i <= 3; i++) begin
      step();
      check("vtx_ov_early", {254'd0, issue, out_valid}, 256'd0);
    end
    step();
    check("vtx_ov", {255'd0, out_valid}, 256'd1);
    step();
    check("vtx_ov_after", {255'd0, out_valid}, 256'd0);
    check("vtx_err", {255'd0, err}, 256'd0);

    // Matrix word right after issue is held until out_valid has fired.
    for (int j = 0; j < 4; j++) send(16'h4000 + 16'(j << 8), 1'b0, w);
    step();
    ov_q.delete();
    send(16'h5000, 1'b1, w);
    check("bp_waits", 256'(w), 256'd4);
    check("bp_ov_seen", 256'(ov_q.size()), 256'd1);
    check("bp_a_hold", a, m3c);
    for (int n = 1; n < 16; n++) begin
      send(16'h5000 + 16'(n), 1'b1, w);
      if (n == 14) check("bp_a_hold15", a, m3c);
    end
    check("bp_a_new", a, m50);

    // Eight vertex words back-to-back.
    step(); step();
    iss_q.delete(); ov_q.delete();
    for (int j = 0; j < 8; j++) send(16'h4400 + 16'(j), 1'b0, w);
    for (int i = 0; i < 6; i++) step();
    check("b2b_issues", 256'(iss_q.size()), 256'd2);
    check("b2b_ovs", 256'(ov_q.size()), 256'd2);
    g0 = (iss_q.size() >= 2) ? iss_q[1] - iss_q[0] : -1;
    g1 = (ov_q.size() >= 2) ? ov_q[1] - ov_q[0] : -1;
    g2 = (iss_q.size() >= 1 && ov_q.size() >= 1) ? ov_q[0] - iss_q[0] : -1;
    check("b2b_issue_gap", 256'(g0), 256'd4);
    check("b2b_ov_gap", 256'(g1), 256'd4);
    check("b2b_latency", 256'(g2), 256'd4);
    check("b2b_b", {192'd0, b}, {192'd0, 64'h4407_4406_4405_4404});

    // Partial vertex interrupted by a matrix word.
    check("pre_err", {255'd0, err}, 256'd0);
    send(16'h4A00, 1'b0, w);
    send(16'h4A01, 1'b0, w);
    send(16'h6000, 1'b1, w);
    check("abort_err", {255'd0, err}, 256'd1);
    check("abort_a", a, m50);
    for (int j = 0; j < 4; j++) send(16'h4B00 + 16'(j), 1'b0, w);
    check("abort_issue", {255'd0, issue}, 256'd1);
    check("abort_b", {192'd0, b}, {192'd0, 64'h4B03_4B02_4B01_4B00});

    // Reset two cycles after issue: result never reported.
    for (int i = 0; i < 6; i++) step();
    for (int j = 0; j < 4; j++) send(16'h4C00 + 16'(j), 1'b0, w);
    check("fl_issue", {255'd0, issue}, 256'd1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("fl_rst_a", a, 256'd0);
    check("fl_rst_b", {192'd0, b}, 256'd0);
    check("fl_rst_flags", {251'd0, issue, out_valid, mat_loaded, err, in_ready}, 256'd1);
    ov_q.delete();
    for (int i = 0; i < 8; i++) step();
    check("fl_no_ov", 256'(ov_q.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/matmul_feeder.md
MATMUL_FEEDER -- requirements
Module: matmul_feeder

Interface
REQ-001 SHALL have parameter MM_LATENCY, default 4: cycles from a b update (issue high) to the matching downstream matmul result being valid.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  16  fp16 word (matrix coefficient or vertex component).
REQ-005 SHALL have port in_mat  input  1  1 = matrix word, 0 = vertex word.
REQ-006 SHALL have port in_valid  input  1  word present.
REQ-007 SHALL have port in_ready  output  1  word accepted when in_valid && in_ready.
REQ-008 SHALL have port a  output  256  committed 4x4 matrix; element k at bits [16k+15:16k].
REQ-009 SHALL have port b  output  64  current vertex; component j at bits [16j+15:16j].
REQ-010 SHALL have port issue  output  1  one-cycle pulse in the cycle b takes a new vertex.
REQ-011 SHALL have port out_valid  output  1  issue delayed by exactly MM_LATENCY cycles.
REQ-012 SHALL have port mat_loaded  output  1  a holds a complete matrix.
REQ-013 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL keep a 16-entry matrix shadow buffer, 4-bit mat_idx, 4-entry vertex buffer, 2-bit vtx_idx, and MM_LATENCY-deep in-flight shift register.
REQ-015 SHALL define busy = any bit of the in-flight shift register set, or issue high.
REQ-016 SHALL drive in_ready = ~(in_mat && busy); vertex words are always accepted.
REQ-017 SHALL, on accepted matrix word, write shadow[mat_idx] (or transposed index, REQ-027) and increment mat_idx, wrapping 15->0.
REQ-018 SHALL, on accepted matrix word at mat_idx 15, copy the full shadow (including that word) to a on the next edge and set mat_loaded; a SHALL change at no other time.
REQ-019 SHALL, on accepted matrix word while vtx_idx != 0, clear vtx_idx, discard partial vertex, set err.
REQ-020 SHALL, on accepted vertex word, write vertex[vtx_idx] and increment vtx_idx, wrapping 3->0.
REQ-021 SHALL, on 4th vertex word with mat_loaded = 1, load all four components into b and assert issue in the following cycle (latency 1 from last word handshake to issue).
REQ-022 SHALL, on 4th vertex word with mat_loaded = 0, drop the vertex, leave b unchanged, no issue, set err.
REQ-023 SHALL sustain one issue per 4 vertex words back-to-back without bubbles.
REQ-024 SHALL assert out_valid exactly MM_LATENCY cycles after each issue, one cycle per issue, order preserved.
REQ-025 SHALL hold b and a stable between issues/commits; err SHALL clear only by reset.

Reset
REQ-026 SHALL, while rst is high at a clock edge, clear a, b, issue, out_valid, mat_loaded, err, mat_idx, vtx_idx, shadow, vertex buffer and shift register; in_ready SHALL be 1 during and after reset; in-flight results at reset SHALL never produce out_valid.

Configuration
REQ-027 SHALL support macro MATMUL_FEEDER_TRANSPOSE_EN: defined -> matrix words are column-major (word n written to element 4*(n%4)+n/4); undefined -> row-major (word n to element n).

Verification
REQ-028 Reset, then 16 matrix words 0x3C00..0x3C0F, then vertex 0x4000,0x4100,0x4200,0x4300 -> mat_loaded=1, a element k=0x3C00+k, b=0x4300_4200_4100_4000, issue 1 cycle after 4th word, out_valid 4 cycles after issue.
REQ-029 Vertex 4 words before any matrix -> no issue, b=0, err=1.
REQ-030 Matrix loaded, 8 vertex words back-to-back -> two issue pulses 4 cycles apart, two out_valid pulses 4 cycles apart.
REQ-031 Matrix word presented in cycle after issue -> in_ready=0 until out_valid fires, then word accepted; a unchanged until 16th word.
REQ-032 Two vertex words then a matrix word -> vtx_idx cleared, err=1, next 4 vertex words issue correctly.
REQ-033 With MATMUL_FEEDER_TRANSPOSE_EN defined, words 0..15 -> a element 1 = word 4, element 4 = word 1; rst asserted 2 cycles after issue -> out_valid never asserts.
